mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have no parameters; widths are fixed at 32-bit data/address and 5-bit register index.
REQ-002 clk  in  1  single clock; all state on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 alu_result_in  in  32  effective address or ALU result, from EX/MEM.
REQ-005 rs2_val_in  in  32  store data.
REQ-006 rd_in  in  5  destination register.
REQ-007 funct3_in  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 MemRead_in, MemWrite_in  in  1 each  load or store request; both high is illegal and treated as load.
REQ-009 MemToReg_in, RegWrite_in  in  1 each  writeback controls.
REQ-010 mem_req  out  1  bus request, registered.
REQ-011 mem_we  out  1  write enable.
REQ-012 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-013 mem_wdata  out  32  store data replicated across byte lanes.
REQ-014 mem_wstrb  out  4  byte-lane strobes, zero for loads.
REQ-015 mem_rdata  in  32  read data, valid when mem_ready=1.
REQ-016 mem_ready  in  1  bus completes the request this cycle.
REQ-017 alu_result_out, rd_out, MemToReg_out  out  32/5/1  pass-through to MEM/WB.
REQ-018 read_data_out  out  32  aligned, extended load data.
REQ-019 RegWrite_out  out  1  RegWrite_in gated to 0 while stall_out=1 or on misalign.
REQ-020 stall_out  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; MEM/WB receives a bubble.
REQ-021 misalign_out  out  1  one-cycle misaligned-access flag.

Function
REQ-022 FSM SHALL have the states IDLE, BUSY and DONE.
REQ-023 IDLE with no memory op: stall_out=0, outputs pass through, zero latency.
REQ-024 IDLE with an aligned memory op:
- stall_out=1.
- Register address, strobes and data.
- Next state BUSY.
REQ-025 BUSY:
- mem_req=1, stall_out=1.
- Bus outputs held stable until mem_ready.
- On mem_ready, capture formatted mem_rdata into read-data register and go to DONE.
- Wait states are unbounded.
REQ-026 DONE:
- stall_out=0, mem_req=0, read_data_out = captured value.
- Next state IDLE unconditionally.
- The inputs still present in DONE SHALL NOT start a new request.
REQ-027 Minimum memory-op latency SHALL be 2 stall cycles (IDLE, BUSY with immediate mem_ready); each wait cycle adds 1.
REQ-028 Load formatting from addr[1:0]:
- LB/LBU select a byte, sign- or zero-extended.
- LH/LHU select a half by addr[1], sign- or zero-extended.
- LW returns the full word.
REQ-029 Store strobes:
- SB: 0001<<addr[1:0].
- SH: 0011<<{addr[1],1'b0}.
- SW: 1111.
REQ-030 Misaligned access is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0; handling is per REQ-034.
REQ-031 read_data_out SHALL equal 0 for non-load instructions.

Reset
REQ-032 Asserting rst in any state, including BUSY mid-transaction, SHALL immediately force state=IDLE and clear all registers and outputs to 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, read_data_out, stall_out, misalign_out).
REQ-033 The bus SHALL treat a dropped mem_req as an abandoned request.

Configuration
REQ-034 MAU_MISALIGN_TRAP_EN:
- Defined: a misaligned op in IDLE issues no request, asserts misalign_out for 1 cycle, forces RegWrite_out=0 and does not stall.
- Undefined: misalign_out is tied to 0 and offending low address bits are treated as 0.

Structure
REQ-035 Shared package riscv_mem_pkg SHALL hold the funct3 size constants and the IDLE/BUSY/DONE state encoding.
REQ-036 Combinational sub-module load_align SHALL perform lane select and extension.

Verification
REQ-037 SW addr 0x104, data 0xDEADBEEF, mem_ready on first BUSY cycle -> mem_addr=0x104, wstrb=1111, stall_out high exactly 2 cycles.
REQ-038 LB addr 0x203, mem_rdata 0x80000000 -> read_data_out=0xFFFFFF80; LBU -> 0x00000080.
REQ-039 LH addr 0x302 with 3 wait cycles, mem_rdata 0x7FFF1234 -> stall 5 cycles, read_data_out=0x00007FFF, RegWrite_out high only in DONE.
REQ-040 rst asserted in BUSY -> mem_req=0 and stall_out=0 immediately; next op starts from IDLE.
REQ-041 LW addr 0x101 with macro defined -> no mem_req, misalign_out 1 cycle, RegWrite_out=0; without macro -> word read at 0x100.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
// Shared definitions for the memory access stage: funct3 size/sign codes,
// the IDLE/BUSY/DONE state encoding and small helpers that map a request
// onto byte lanes.
package riscv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mau_state_t;

   // Byte offset actually used for lane selection: the low address bits
   // that cannot be honoured for the access size are forced to zero.
   function automatic logic [1:0] eff_offset(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_B, F3_BU: return a;
         F3_H, F3_HU: return {a[1], 1'b0};
         default:     return 2'b00;
      endcase
   endfunction

   // True when the low address bits do not fit the access size.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_B, F3_BU: return 1'b0;
         F3_H, F3_HU: return a[0];
         default:     return (a != 2'b00);
      endcase
   endfunction

   // Byte-lane strobes for a store at the given effective offset.
   function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         F3_B:    return 4'b0001 << off;
         F3_H:    return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   // Store data replicated so every enabled lane carries the operand.
   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         F3_B:    return {4{d[7:0]}};
         F3_H:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// load_align
// Combinational lane select and sign/zero extension of a read word.
// Ports:
//   rdata  - raw 32-bit word from the bus
//   offset - effective byte offset within the word
//   funct3 - access size/sign code
//   data   - aligned, extended load result
module load_align
   import riscv_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte/half, then extend according to funct3.
   always_comb begin
      case (offset)
         2'b00:   byte_sel = rdata[7:0];
         2'b01:   byte_sel = rdata[15:8];
         2'b10:   byte_sel = rdata[23:16];
         2'b11:   byte_sel = rdata[31:24];
         default: byte_sel = 8'h00;
      endcase
      if (offset[1]) begin
         half_sel = rdata[31:16];
      end else begin
         half_sel = rdata[15:0];
      end
      case (funct3)
         F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data = {24'h000000, byte_sel};
         F3_H:    data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data = {16'h0000, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// MEM stage of the pipeline: turns a load/store from EX/MEM into a single
// bus transaction, stalls the front of the pipeline while it is in flight
// and hands aligned load data to MEM/WB.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   alu_result_in, rs2_val_in     - address / store data from EX/MEM
//   rd_in, funct3_in              - destination register, size/sign code
//   MemRead_in, MemWrite_in       - load / store request (both = load)
//   MemToReg_in, RegWrite_in      - writeback controls
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_wstrb          - registered bus request
//   mem_rdata, mem_ready          - bus response
//   alu_result_out, rd_out,
//   MemToReg_out, RegWrite_out,
//   read_data_out                 - towards MEM/WB
//   stall_out                     - freezes earlier stages
//   misalign_out                  - misaligned-access flag
// Build option: MAU_MISALIGN_TRAP_EN makes misaligned accesses trap instead
// of silently clearing the offending low address bits.
module mem_access_unit
   import riscv_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] rs2_val_in,
   input  logic [4:0]  rd_in,
   input  logic [2:0]  funct3_in,
   input  logic        MemRead_in,
   input  logic        MemWrite_in,
   input  logic        MemToReg_in,
   input  logic        RegWrite_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] alu_result_out,
   output logic [4:0]  rd_out,
   output logic        MemToReg_out,
   output logic [31:0] read_data_out,
   output logic        RegWrite_out,
   output logic        stall_out,
   output logic        misalign_out
);

   mau_state_t  state;
   logic        is_load;
   logic        is_store;
   logic        mem_op;
   logic        trap;
   logic        start;
   logic [1:0]  off;
   logic [2:0]  f3_r;
   logic [1:0]  off_r;
   logic        load_r;
   logic [31:0] rdata_r;
   logic [31:0] fmt_data;

   load_align u_load_align (
      .rdata  (mem_rdata),
      .offset (off_r),
      .funct3 (f3_r),
      .data   (fmt_data)
   );

   // Request decode; a simultaneous read and write is handled as a load.
   always_comb begin
      is_load  = MemRead_in;
      is_store = MemWrite_in & ~MemRead_in;
      mem_op   = is_load | is_store;
      off      = eff_offset(funct3_in, alu_result_in[1:0]);
`ifdef MAU_MISALIGN_TRAP_EN
      trap     = mem_op & is_misaligned(funct3_in, alu_result_in[1:0]);
`else
      trap     = 1'b0;
`endif
      start    = (state == IDLE) & mem_op & ~trap;
   end

   // Stage outputs; stall covers the issuing IDLE cycle and all of BUSY so
   // the minimum stall is two cycles.
   always_comb begin
      alu_result_out = alu_result_in;
      rd_out         = rd_in;
      MemToReg_out   = MemToReg_in;
      stall_out      = ~rst & (start | (state == BUSY));
      misalign_out   = ~rst & (state == IDLE) & trap;
      RegWrite_out   = RegWrite_in & ~stall_out & ~misalign_out;
      if (state == DONE) begin
         read_data_out = rdata_r;
      end else begin
         read_data_out = 32'h0000_0000;
      end
   end

   // Transaction FSM with registered bus outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0000_0000;
         mem_wdata <= 32'h0000_0000;
         mem_wstrb <= 4'b0000;
         f3_r      <= 3'b000;
         off_r     <= 2'b00;
         load_r    <= 1'b0;
         rdata_r   <= 32'h0000_0000;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= BUSY;
                  mem_req  <= 1'b1;
                  mem_we   <= is_store;
                  mem_addr <= {alu_result_in[31:2], 2'b00};
                  f3_r     <= funct3_in;
                  off_r    <= off;
                  load_r   <= is_load;
                  if (is_store) begin
                     mem_wdata <= store_lanes(funct3_in, rs2_val_in);
                     mem_wstrb <= store_strobe(funct3_in, off);
                  end else begin
                     mem_wdata <= 32'h0000_0000;
                     mem_wstrb <= 4'b0000;
                  end
               end
            end
            BUSY: begin
               // Bus outputs stay put for as many wait states as the bus needs.
               if (mem_ready) begin
                  state     <= DONE;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= 32'h0000_0000;
                  mem_wdata <= 32'h0000_0000;
                  mem_wstrb <= 4'b0000;
                  if (load_r) begin
                     rdata_r <= fmt_data;
                  end else begin
                     rdata_r <= 32'h0000_0000;
                  end
               end
            end
            DONE: begin
               // The frozen EX/MEM still holds this op; never reissue it.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_result_in;
   logic [31:0] rs2_val_in;
   logic [4:0]  rd_in;
   logic [2:0]  funct3_in;
   logic        MemRead_in;
   logic        MemWrite_in;
   logic        MemToReg_in;
   logic        RegWrite_in;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [31:0] alu_result_out;
   logic [4:0]  rd_out;
   logic        MemToReg_out;
   logic [31:0] read_data_out;
   logic        RegWrite_out;
   logic        stall_out;
   logic        misalign_out;

   int tests = 0;
   int fails = 0;
   int wait_cycles = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        rw;
      logic [31:0] stall;
   } wb_exp_t;

   bus_exp_t bus_q[$];
   wb_exp_t  wb_q[$];

   mem_access_unit dut (
      .clk            (clk),
      .rst            (rst),
      .alu_result_in  (alu_result_in),
      .rs2_val_in     (rs2_val_in),
      .rd_in          (rd_in),
      .funct3_in      (funct3_in),
      .MemRead_in     (MemRead_in),
      .MemWrite_in    (MemWrite_in),
      .MemToReg_in    (MemToReg_in),
      .RegWrite_in    (RegWrite_in),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wstrb      (mem_wstrb),
      .mem_rdata      (mem_rdata),
      .mem_ready      (mem_ready),
      .alu_result_out (alu_result_out),
      .rd_out         (rd_out),
      .MemToReg_out   (MemToReg_out),
      .read_data_out  (read_data_out),
      .RegWrite_out   (RegWrite_out),
      .stall_out      (stall_out),
      .misalign_out   (misalign_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_nop();
      alu_result_in = 32'h0;
      rs2_val_in    = 32'h0;
      rd_in         = 5'd0;
      funct3_in     = 3'b000;
      MemRead_in    = 1'b0;
      MemWrite_in   = 1'b0;
      MemToReg_in   = 1'b0;
      RegWrite_in   = 1'b0;
   endtask

   // Issue one memory op, push its expected bus request and writeback,
   // hold the inputs while stalled, then retire it.
   task automatic do_op(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdat, input int waits, input logic rw,
                        input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_strb,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                        input int e_stall);
      int n;
      bus_q.push_back('{addr: e_addr, we: e_we, strb: e_strb, wdata: e_wdata});
      wb_q.push_back('{rdata: e_rdata, rw: rw, stall: e_stall});
      wait_cycles   = waits;
      mem_rdata     = rdat;
      alu_result_in = addr;
      rs2_val_in    = wd;
      rd_in         = 5'd5;
      funct3_in     = f3;
      MemRead_in    = mr;
      MemWrite_in   = mw;
      MemToReg_in   = mr;
      RegWrite_in   = rw;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (stall_out && n < 50);
      check("op_timeout", {31'd0, stall_out}, 32'd0);
      @(posedge clk); #1;
      drive_nop();
   endtask

   // Bus responder: raises mem_ready after wait_cycles BUSY cycles.
   initial begin
      int cnt;
      cnt = 0;
      mem_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            mem_ready = (cnt == wait_cycles);
            cnt++;
         end else begin
            mem_ready = 1'b0;
            cnt = 0;
         end
      end
   end

   // Monitor: checks each new bus request and each completed stall window
   // against the scoreboard queues.
   initial begin
      logic prev_req;
      logic prev_stall;
      int   scnt;
      bus_exp_t b;
      wb_exp_t  w;
      prev_req = 1'b0;
      prev_stall = 1'b0;
      scnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req = 1'b0;
            prev_stall = 1'b0;
            scnt = 0;
         end else begin
            if (mem_req && !prev_req) begin
               if (bus_q.size() == 0) begin
                  check("unexpected_req", 32'd1, 32'd0);
               end else begin
                  b = bus_q.pop_front();
                  check("bus_addr", mem_addr, b.addr);
                  check("bus_we", {31'd0, mem_we}, {31'd0, b.we});
                  check("bus_wstrb", {28'd0, mem_wstrb}, {28'd0, b.strb});
                  check("bus_wdata", mem_wdata, b.wdata);
               end
            end
            if (stall_out) begin
               scnt++;
               check("regwrite_in_stall", {31'd0, RegWrite_out}, 32'd0);
            end else if (prev_stall) begin
               if (wb_q.size() == 0) begin
                  check("unexpected_wb", 32'd1, 32'd0);
               end else begin
                  w = wb_q.pop_front();
                  check("read_data", read_data_out, w.rdata);
                  check("regwrite_done", {31'd0, RegWrite_out}, {31'd0, w.rw});
                  check("stall_cycles", scnt, w.stall);
               end
               scnt = 0;
            end
            prev_req = mem_req;
            prev_stall = stall_out;
         end
      end
   end

   initial begin
      rst = 1'b1;
      mem_rdata = 32'h0;
      drive_nop();
      @(negedge clk);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_stall", {31'd0, stall_out}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
      check("rst_rdata", read_data_out, 32'd0);
      check("rst_misalign", {31'd0, misalign_out}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Non-memory op passes straight through with no stall.
      alu_result_in = 32'h1234_5678;
      rd_in = 5'd7;
      MemToReg_in = 1'b1;
      RegWrite_in = 1'b1;
      #1;
      check("pt_alu", alu_result_out, 32'h1234_5678);
      check("pt_rd", {27'd0, rd_out}, 32'd7);
      check("pt_memtoreg", {31'd0, MemToReg_out}, 32'd1);
      check("pt_regwrite", {31'd0, RegWrite_out}, 32'd1);
      check("pt_stall", {31'd0, stall_out}, 32'd0);
      check("pt_rdata", read_data_out, 32'd0);
      @(posedge clk); #1;
      check("pt_no_req", {31'd0, mem_req}, 32'd0);
      drive_nop();

      //    mr    mw    f3      addr          wdata          rdata          w  rw    e_addr        we    strb     e_wdata        e_rdata        stall
      do_op(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         0, 1'b0, 32'h0000_0104, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0,         2);
      do_op(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0,         32'h8000_0000, 0, 1'b1, 32'h0000_0200, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FF80, 2);
      do_op(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0,         32'h8000_0000, 0, 1'b1, 32'h0000_0200, 1'b0, 4'b0000, 32'h0,         32'h0000_0080, 2);
      do_op(1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'h0,         32'h7FFF_1234, 3, 1'b1, 32'h0000_0300, 1'b0, 4'b0000, 32'h0,         32'h0000_7FFF, 5);
      do_op(1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'h0,         1, 1'b0, 32'h0000_0000, 1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0,         3);
      do_op(1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h1234_BEEF, 32'h0,         0, 1'b0, 32'h0000_0010, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0,         2);
      do_op(1'b1, 1'b0, 3'b001, 32'h0000_0500, 32'h0,         32'h1234_8001, 0, 1'b1, 32'h0000_0500, 1'b0, 4'b0000, 32'h0,         32'hFFFF_8001, 2);
      do_op(1'b1, 1'b0, 3'b101, 32'h0000_0502, 32'h0,         32'hFFEE_0001, 2, 1'b1, 32'h0000_0500, 1'b0, 4'b0000, 32'h0,         32'h0000_FFEE, 4);
      do_op(1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'h5555_5555, 32'h1122_3344, 0, 1'b1, 32'h0000_0020, 1'b0, 4'b0000, 32'h0,         32'h1122_3344, 2);

      // Reset in the middle of a long transaction.
      bus_q.push_back('{addr: 32'h0000_0400, we: 1'b0, strb: 4'b0000, wdata: 32'h0});
      wait_cycles = 10;
      alu_result_in = 32'h0000_0400;
      funct3_in = 3'b010;
      MemRead_in = 1'b1;
      RegWrite_in = 1'b1;
      @(posedge clk); #1;
      check("busy_req", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rstbusy_req", {31'd0, mem_req}, 32'd0);
      check("rstbusy_stall", {31'd0, stall_out}, 32'd0);
      check("rstbusy_addr", mem_addr, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drive_nop();
      do_op(1'b0, 1'b1, 3'b000, 32'h0000_0041, 32'h0000_0077, 32'h0,         0, 1'b0, 32'h0000_0040, 1'b1, 4'b0010, 32'h7777_7777, 32'h0,         2);

      // Misaligned word load.
`ifdef MAU_MISALIGN_TRAP_EN
      alu_result_in = 32'h0000_0101;
      funct3_in = 3'b010;
      MemRead_in = 1'b1;
      RegWrite_in = 1'b1;
      #1;
      check("trap_flag", {31'd0, misalign_out}, 32'd1);
      check("trap_stall", {31'd0, stall_out}, 32'd0);
      check("trap_regwrite", {31'd0, RegWrite_out}, 32'd0);
      @(posedge clk); #1;
      check("trap_no_req", {31'd0, mem_req}, 32'd0);
      drive_nop();
      #1;
      check("trap_flag_clear", {31'd0, misalign_out}, 32'd0);
`else
      do_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,         32'hCAFE_F00D, 0, 1'b1, 32'h0000_0100, 1'b0, 4'b0000, 32'h0,         32'hCAFE_F00D, 2);
      check("no_trap_flag", {31'd0, misalign_out}, 32'd0);
`endif

      repeat (4) @(posedge clk);
      #1;
      check("bus_q_empty", bus_q.size(), 32'd0);
      check("wb_q_empty", wb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
